// File: rtl/io_bank_pkg.sv
// io_bank_pkg
// Shared definitions for the memory-mapped output port bank:
//   - op alias encodings carried in addr[9:8]
//   - address field positions used by the decoder
//   - pulse channel FSM state encoding
//   - apply_op helper that evaluates one write alias on a 32-bit word
package io_bank_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_TGL   = 2'b11
  } io_op_e;

  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

  // Word index lives in addr[7:2]; the op alias in addr[9:8].
  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = 7;
  localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;
  localparam int OP_LSB  = 8;
  localparam int OP_MSB  = 9;
  localparam int BUS_W   = 32;

  function automatic logic [BUS_W-1:0] apply_op(
    input io_op_e           op,
    input logic [BUS_W-1:0] cur,
    input logic [BUS_W-1:0] d
  );
    logic [BUS_W-1:0] res;
    case (op)
      OP_WRITE: res = d;
      OP_SET:   res = cur | d;
      OP_CLR:   res = cur & ~d;
      default:  res = cur ^ d;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/io_pulse_channel.sv
// io_pulse_channel
// Auto-clearing pulse output. A write hit ORs the write data into the
// pulse register and (re)arms a down-counter for PULSE_CYCLES cycles; when
// the counter expires the register clears and the channel returns to IDLE.
// Ports:
//   io_clk     in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   wr_hit     in   write strobe already qualified by the address decoder
//   wr_data    in   DATA_W bits to OR into the pulse register
//   pulse_out  out  DATA_W pulse register value (0 while IDLE)
module io_pulse_channel
  import io_bank_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int PULSE_CYCLES = 16
) (
  input  logic              io_clk,
  input  logic              resetn,
  input  logic              wr_hit,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] pulse_out
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  pulse_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pulse_q, pulse_d;

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= PULSE_IDLE;
      cnt_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    case (state_q)
      PULSE_ACTIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = PULSE_IDLE;
          cnt_d   = '0;
          pulse_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      default: begin
        pulse_d = '0;
      end
    endcase
    // A write wins over expiry in the same cycle and always rearms,
    // even when the data is zero.
    if (wr_hit) begin
      state_d = PULSE_ACTIVE;
      cnt_d   = CNT_LOAD;
      pulse_d = pulse_q | wr_data;
    end
  end

  assign pulse_out = pulse_q;

endmodule

// File: rtl/io_output_bank.sv
// io_output_bank
// Memory-mapped bank of NPORTS registered output ports plus one pulse
// channel, written from the MEM stage with write/set/clear/toggle aliases
// selected by addr[9:8], and a one-cycle-latency registered readback.
// Ports:
//   io_clk           in   clock, rising edge
//   resetn           in   asynchronous active-low reset
//   addr             in   byte address, addr[9:2] decoded
//   datain           in   write data, low DATA_W bits used
//   write_io_enable  in   write qualifier
//   read_io_enable   in   readback qualifier
//   out_ports        out  port i at [i*DATA_W +: DATA_W]
//   out_wr           out  per-port strobe, high the cycle after a write hit
//   pulse_out        out  auto-clearing pulse channel
//   rdata            out  registered readback, zero-extended
//   rvalid           out  rdata valid this cycle
module io_output_bank
  import io_bank_pkg::*;
#(
  parameter int         NPORTS       = 4,
  parameter int         DATA_W       = 32,
  parameter logic [7:0] BASE_ADDR    = 8'h80,
  parameter int         PULSE_CYCLES = 16
) (
  input  logic                     io_clk,
  input  logic                     resetn,
  input  logic [31:0]              addr,
  input  logic [31:0]              datain,
  input  logic                     write_io_enable,
  input  logic                     read_io_enable,
  output logic [NPORTS*DATA_W-1:0] out_ports,
  output logic [NPORTS-1:0]        out_wr,
  output logic [DATA_W-1:0]        pulse_out,
  output logic [31:0]              rdata,
  output logic                     rvalid
);

  logic [IDX_W-1:0]  idx;
  io_op_e            op;
  logic [DATA_W-1:0] wdata;
  logic [NPORTS-1:0] port_sel;
  logic              pulse_hit;
  logic [DATA_W-1:0] port_q [NPORTS];
  logic [DATA_W-1:0] port_d [NPORTS];
  logic [NPORTS-1:0] out_wr_q;
  logic [31:0]       rd_word;
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              unused_bits;

  // Subtracting the base index makes the hit window relocatable; an
  // address below the base wraps to a large index and simply misses.
  assign idx   = addr[IDX_MSB:IDX_LSB] - BASE_ADDR[IDX_MSB:IDX_LSB];
  assign op    = io_op_e'(addr[OP_MSB:OP_LSB]);
  assign wdata = datain[DATA_W-1:0];

  assign unused_bits = ^{addr[31:OP_MSB+1], addr[IDX_LSB-1:0], datain};

  always_comb begin
    port_sel = '0;
    for (int i = 0; i < NPORTS; i++) begin
      port_sel[i] = (idx == IDX_W'(i));
    end
    pulse_hit = (idx == IDX_W'(NPORTS));
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      port_d[i] = DATA_W'(apply_op(op, BUS_W'(port_q[i]), BUS_W'(wdata)));
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NPORTS; i++) begin
        port_q[i] <= '0;
      end
      out_wr_q <= '0;
    end else begin
      out_wr_q <= '0;
      if (write_io_enable) begin
        for (int i = 0; i < NPORTS; i++) begin
          if (port_sel[i]) begin
            port_q[i]   <= port_d[i];
            out_wr_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  io_pulse_channel #(
    .DATA_W       (DATA_W),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse (
    .io_clk    (io_clk),
    .resetn    (resetn),
    .wr_hit    (write_io_enable & pulse_hit),
    .wr_data   (wdata),
    .pulse_out (pulse_out)
  );

  // Readback uses the current register values, so a same-cycle write is
  // not visible until the following read.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (port_sel[i]) begin
        rd_word[DATA_W-1:0] = port_q[i];
      end
    end
    if (pulse_hit) begin
      rd_word[DATA_W-1:0] = pulse_out;
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= read_io_enable;
      rdata_q  <= read_io_enable ? rd_word : '0;
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_out
    assign out_ports[g*DATA_W +: DATA_W] = port_q[g];
  end

  assign out_wr = out_wr_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_io_output_bank.sv
// tb_io_output_bank
// Scoreboard bench: the stimulus process drives one transaction per cycle
// at the falling edge and pushes the expected post-edge state and any
// expected readback into queues; the monitor samples just after each rising
// edge and pops/compares. Expected values come from a word-level model of
// the port bank and a pulse channel tracked as "value + last high edge".
module tb_io_output_bank;
  localparam int NPORTS       = 4;
  localparam int DATA_W       = 32;
  localparam int PULSE_CYCLES = 16;

  logic                     io_clk = 1'b0;
  logic                     resetn = 1'b0;
  logic [31:0]              addr = '0;
  logic [31:0]              datain = '0;
  logic                     write_io_enable = 1'b0;
  logic                     read_io_enable = 1'b0;
  logic [NPORTS*DATA_W-1:0] out_ports;
  logic [NPORTS-1:0]        out_wr;
  logic [DATA_W-1:0]        pulse_out;
  logic [31:0]              rdata;
  logic                     rvalid;

  io_output_bank #(
    .NPORTS       (NPORTS),
    .DATA_W       (DATA_W),
    .BASE_ADDR    (8'h80),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) dut (
    .io_clk          (io_clk),
    .resetn          (resetn),
    .addr            (addr),
    .datain          (datain),
    .write_io_enable (write_io_enable),
    .read_io_enable  (read_io_enable),
    .out_ports       (out_ports),
    .out_wr          (out_wr),
    .pulse_out       (pulse_out),
    .rdata           (rdata),
    .rvalid          (rvalid)
  );

  always #5 io_clk = ~io_clk;

  typedef struct packed {
    logic [127:0] ports;
    logic [3:0]   wr;
    logic [31:0]  pulse;
  } snap_t;

  snap_t       exp_state_q[$];
  logic [31:0] exp_rd_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  logic [31:0] m_port [4];
  logic [31:0] m_pulse;
  int          m_last;
  int          m_edge;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_port[i] = '0;
    m_pulse = '0;
    m_last  = -1000;
  endtask

  // One bus transaction sampled on the next rising edge.
  task automatic cyc(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    snap_t s;
    int idx;
    int op;
    logic [31:0] rv;
    @(negedge io_clk);
    write_io_enable = wr;
    read_io_enable  = rd;
    addr            = a;
    datain          = d;
    m_edge++;
    idx = (int'(a[7:2]) + 32) % 64;
    op  = int'(a[9:8]);
    if (rd) begin
      rv = '0;
      if (idx < 4) rv = m_port[idx];
      else if (idx == 4) rv = m_pulse;
      exp_rd_q.push_back(rv);
    end
    s.wr = '0;
    if (wr && idx < 4) begin
      case (op)
        0: m_port[idx] = d;
        1: m_port[idx] = m_port[idx] | d;
        2: m_port[idx] = m_port[idx] & ~d;
        default: m_port[idx] = m_port[idx] ^ d;
      endcase
      s.wr[idx] = 1'b1;
    end
    if (wr && idx == 4) begin
      m_pulse = m_pulse | d;
      m_last  = m_edge + PULSE_CYCLES - 1;
    end else if (m_edge > m_last) begin
      m_pulse = '0;
    end
    s.ports = {m_port[3], m_port[2], m_port[1], m_port[0]};
    s.pulse = m_pulse;
    exp_state_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Direct spot check right after the edge that the last cyc() targeted.
  task automatic expect_port(input int i, input logic [31:0] v);
    @(posedge io_clk);
    #2;
    check($sformatf("port%0d_direct", i), 128'(out_ports[i*32 +: 32]), 128'(v));
  endtask

  task automatic async_reset(input bit expect_pulse);
    @(negedge io_clk);
    write_io_enable = 1'b0;
    read_io_enable  = 1'b0;
    if (expect_pulse) check("pulse_live_before_reset", 128'(pulse_out != '0), 128'(1));
    #2 resetn = 1'b0;
    #1;
    check("async_rst_ports", 128'(out_ports), 128'(0));
    check("async_rst_out_wr", 128'(out_wr), 128'(0));
    check("async_rst_pulse", 128'(pulse_out), 128'(0));
    check("async_rst_rvalid", 128'(rvalid), 128'(0));
    check("async_rst_rdata", 128'(rdata), 128'(0));
    model_reset();
    @(negedge io_clk);
    resetn = 1'b1;
  endtask

  // Monitor
  snap_t mon_s;
  always @(posedge io_clk) begin
    #1;
    if (exp_state_q.size() > 0) begin
      mon_s = exp_state_q.pop_front();
      check("out_ports", 128'(out_ports), mon_s.ports);
      check("out_wr", 128'(out_wr), 128'(mon_s.wr));
      check("pulse_out", 128'(pulse_out), 128'(mon_s.pulse));
    end
    if (rvalid) begin
      if (exp_rd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_rvalid: got rvalid=1 rdata %h expected no read at %0t", rdata, $time);
      end else begin
        check("rdata", 128'(rdata), 128'(exp_rd_q.pop_front()));
      end
    end else if (exp_rd_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_rvalid: got rvalid=0 expected 1 (rdata %h) at %0t", exp_rd_q.pop_front(), $time);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    model_reset();
    m_edge = 0;

    // Reset state
    #12;
    check("reset_ports", 128'(out_ports), 128'(0));
    check("reset_out_wr", 128'(out_wr), 128'(0));
    check("reset_pulse", 128'(pulse_out), 128'(0));
    check("reset_rvalid", 128'(rvalid), 128'(0));
    check("reset_rdata", 128'(rdata), 128'(0));
    @(negedge io_clk);
    resetn = 1'b1;

    // Plain write, port 0
    cyc(1'b1, 1'b0, 32'h80, 32'h1234_5678);
    expect_port(0, 32'h1234_5678);
    idle(1);

    // Alias ops on port 1
    cyc(1'b1, 1'b0, 32'h084, 32'h0000_F0F0);
    cyc(1'b1, 1'b0, 32'h184, 32'h0000_000F);
    expect_port(1, 32'h0000_F0FF);
    cyc(1'b1, 1'b0, 32'h284, 32'h0000_00F0);
    expect_port(1, 32'h0000_F00F);
    cyc(1'b1, 1'b0, 32'h384, 32'h0000_FFFF);
    expect_port(1, 32'h0000_0FF0);
    // Unchanged-value write still strobes
    cyc(1'b1, 1'b0, 32'h184, 32'h0000_0000);
    idle(1);

    // Pulse channel: expiry, then rearm at cycle 10 with OR
    cyc(1'b1, 1'b0, 32'h90, 32'h0000_00A5);
    idle(PULSE_CYCLES + 2);
    cyc(1'b1, 1'b0, 32'h90, 32'h0000_00A5);
    idle(9);
    cyc(1'b1, 1'b0, 32'h90, 32'h0000_005A);
    @(posedge io_clk);
    #2 check("pulse_or_direct", 128'(pulse_out), 128'(32'hFF));
    idle(PULSE_CYCLES + 2);
    // Zero-data write still arms; alias op irrelevant
    cyc(1'b1, 1'b0, 32'h390, 32'h0);
    idle(3);

    // Readback and misses
    cyc(1'b1, 1'b0, 32'h88, 32'h0000_CAFE);
    cyc(1'b0, 1'b1, 32'h88, 32'h0);
    cyc(1'b0, 1'b1, 32'h288, 32'h0);
    cyc(1'b0, 1'b1, 32'hA0, 32'h0);
    cyc(1'b1, 1'b0, 32'hA0, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, 32'h7C, 32'hFFFF_FFFF);
    idle(1);

    // Same-cycle read/write returns the old value
    cyc(1'b1, 1'b0, 32'h8C, 32'h11);
    cyc(1'b1, 1'b1, 32'h8C, 32'h55);
    cyc(1'b0, 1'b1, 32'h8C, 32'h0);
    expect_port(3, 32'h55);
    // Back-to-back reads including the live pulse channel
    cyc(1'b1, 1'b0, 32'h90, 32'h3C);
    cyc(1'b0, 1'b1, 32'h80, 32'h0);
    cyc(1'b0, 1'b1, 32'h84, 32'h0);
    cyc(1'b0, 1'b1, 32'h90, 32'h0);
    idle(2);

    // Asynchronous reset mid-pulse with ports loaded
    async_reset(1'b1);
    idle(2);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      a = $urandom;
      if ($urandom_range(0, 9) < 8) a[7:2] = 6'(32 + $urandom_range(0, 6));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = d & 32'hFF;
      cyc(1'(($urandom_range(0, 2) != 0)), 1'(($urandom_range(0, 2) == 0)), a, d);
      if (k == 200) begin
        cyc(1'b1, 1'b0, 32'h90, 32'h1);
        async_reset(1'b1);
      end
    end
    idle(PULSE_CYCLES + 2);

    @(posedge io_clk);
    #3;
    check("rd_queue_drained", 128'(exp_rd_q.size()), 128'(0));
    check("state_queue_drained", 128'(exp_state_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
